bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, sets the RAM address width.
REQ-002 Parameter DATA_WIDTH, default 16, sets the RAM word width.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  starts a burst read; sampled only when busy=0.
REQ-006 start_addr  input  ADDR_WIDTH  first word address, sampled with start.
REQ-007 len  input  ADDR_WIDTH+1  word count (0..2**ADDR_WIDTH), sampled with start.
REQ-008 mem_addr  output  ADDR_WIDTH  address to the single-port RAM.
REQ-009 mem_write_en  output  1  RAM write enable; held constant 0.
REQ-010 mem_data_in  output  DATA_WIDTH  RAM write data; held constant 0.
REQ-011 mem_data_out  input  DATA_WIDTH  RAM read data, valid one cycle after mem_addr.
REQ-012 m_valid  output  1  stream data valid.
REQ-013 m_ready  input  1  stream sink ready.
REQ-014 m_data  output  DATA_WIDTH  stream data.
REQ-015 busy  output  1  burst in progress.
REQ-016 done  output  1  one-cycle pulse at the end of a burst.

Function
REQ-017 The FSM shall have three states: IDLE, ISSUE and DRAIN; reset enters IDLE.
REQ-018 IDLE->ISSUE on start=1 with len>0; IDLE stays IDLE and done pulses the next cycle on start=1 with len=0; no RAM read is issued in that case.
REQ-019 ISSUE->DRAIN after the last address is issued; DRAIN->IDLE on the handshake of the last word, with done=1 in the cycle after that handshake.
REQ-020 start while busy=1 shall be ignored; the active burst is unaffected.
REQ-021 A read is issued in a cycle when state=ISSUE, issued-word count<len, and (fifo_count + inflight - pop) < 2, where pop = m_valid&&m_ready.
REQ-022 RAM read latency is exactly 1 cycle; the word returned is written into a 2-entry output FIFO at the next edge.
REQ-023 Words shall leave m_data in issue order, with no loss or duplication under any m_ready pattern.
REQ-024 m_valid = FIFO non-empty; m_data = FIFO head; both stable while m_valid=1 and m_ready=0.
REQ-025 First m_valid shall rise 2 cycles after the edge that samples start.
REQ-026 Throughput shall be 1 word/cycle while m_ready=1.
REQ-027 Address arithmetic is modulo 2**ADDR_WIDTH; 2**AW-1 wraps to 0 (0 to 2**AW-1 when descending).
REQ-028 mem_addr shall hold its last value when no read is issued.
REQ-029 busy=1 from the edge that samples start (len>0) until DRAIN exits; busy=0 in the done cycle.

Reset
REQ-030 rst_n=0 at any edge: state=IDLE, FIFO emptied, inflight cleared, counters and mem_addr=0, m_valid=0, m_data=0, busy=0, done=0.
REQ-031 Reset mid-burst shall abort the burst with no done pulse; start is accepted on the first edge with rst_n=1.

Configuration
REQ-032 Macro RD_REVERSE_EN defined: the burst reads descending addresses start_addr, start_addr-1, ... (traceback order).
REQ-033 Macro RD_REVERSE_EN undefined: the burst reads ascending addresses start_addr, start_addr+1, ...
REQ-034 The port list and latency shall be identical in both builds.

Verification
REQ-035 start_addr=0x10, len=4, m_ready=1, RAM holds mem[a]=a -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles; first m_valid at T+2; done at the cycle after the last handshake.
REQ-036 Same burst with RD_REVERSE_EN -> 0x10,0x0F,0x0E,0x0D.
REQ-037 start_addr=0xFE, len=4, ascending -> 0xFE,0xFF,0x00,0x01 (wrap).
REQ-038 len=8 with m_ready toggling pseudo-randomly and held low 5 cycles -> exactly 8 words in order; m_data stable while stalled; at most 2 outstanding words.
REQ-039 len=0 -> no mem_addr change, m_valid never 1, done one cycle after start; a second start while busy during a len=4 burst is ignored.
REQ-040 rst_n=0 after 2 of 6 words -> m_valid=0 and no done; a new burst start_addr=0x20, len=1 then returns 0x20 only.

Source files
------------

// File: rtl/bram_stream_reader.sv
// ----------------------------------------------------------------------------
// bram_stream_reader
//
// Reads a burst of consecutive words from a single-port synchronous RAM and
// streams them out over a valid/ready interface. A 2-entry output FIFO
// absorbs the one-cycle RAM read latency so the stream runs at one word per
// cycle while the sink is ready, and never loses a word when it stalls.
//
// Build option:
//   RD_REVERSE_EN  when defined, the burst walks descending addresses
//                  (start_addr, start_addr-1, ...); otherwise ascending.
//                  Ports and latency are identical in both builds.
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          synchronous active-low reset
//   start          begin a burst (only honoured while busy=0)
//   start_addr     first word address, sampled with start
//   len            number of words, 0..2**ADDR_WIDTH, sampled with start
//   mem_addr       RAM address (holds its value between reads)
//   mem_write_en   RAM write enable, tied to 0
//   mem_data_in    RAM write data, tied to 0
//   mem_data_out   RAM read data, valid one cycle after mem_addr
//   m_valid        stream word available
//   m_ready        stream sink ready
//   m_data         stream word
//   busy           burst in progress
//   done           one-cycle pulse after the last word of a burst
// ----------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_next;

    // Burst bookkeeping
    logic [ADDR_WIDTH-1:0] addr_reg;      // address presented to the RAM
    logic [ADDR_WIDTH-1:0] addr_next;     // following address in burst order
    logic [ADDR_WIDTH:0]   len_reg;       // words requested
    logic [ADDR_WIDTH:0]   issued_cnt;    // reads issued so far
    logic                  inflight;      // a read was issued last cycle
    logic                  done_reg;

    // Output FIFO (2 entries)
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  fifo_wr_ptr;
    logic                  fifo_rd_ptr;
    logic [1:0]            fifo_count;

    // Per-cycle control
    logic       start_ok;    // start accepted with a non-empty burst
    logic       start_zero;  // start accepted with len = 0
    logic       pop;
    logic       push;
    logic [2:0] occupancy;   // FIFO words + word in flight, after this pop
    logic       issue;
    logic       last_issue;
    logic       last_pop;

    // ------------------------------------------------------------------
    // Handshake and occupancy
    // ------------------------------------------------------------------
    assign pop  = (fifo_count != 2'd0) && m_ready;
    assign push = inflight;

    // pop can only be 1 when the FIFO holds a word, so this never underflows.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    assign start_ok   = (state == IDLE) && start && (len != '0);
    assign start_zero = (state == IDLE) && start && (len == '0);

    // The burst's final word leaves when everything has been issued, nothing
    // is in flight, and the FIFO is handing over its only entry.
    assign last_pop = (state == DRAIN) && pop && (fifo_count == 2'd1) && !inflight;

`ifdef RD_REVERSE_EN
    assign addr_next = addr_reg - ADDR_ONE;
`else
    assign addr_next = addr_reg + ADDR_ONE;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: a default assignment ahead of the case keeps every path
        // driven, so no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (start_ok)   state_next = ISSUE;
            ISSUE:   if (last_issue) state_next = DRAIN;
            DRAIN:   if (last_pop)   state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        issue      = 1'b0;
        last_issue = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            ISSUE: begin
                busy = 1'b1;
                // Read only while words remain and the FIFO plus the word in
                // flight leaves room for the one this read will return.
                issue      = (issued_cnt < len_reg) && (occupancy < 3'd2);
                last_issue = issue && ((issued_cnt + CNT_ONE) == len_reg);
            end
            DRAIN: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address generation and burst counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg   <= '0;
            len_reg    <= '0;
            issued_cnt <= '0;
            inflight   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            if (start_ok) begin
                // The first address is presented immediately so the first
                // read can go out in the first ISSUE cycle.
                addr_reg   <= start_addr;
                len_reg    <= len;
                issued_cnt <= '0;
            end else if (issue) begin
                issued_cnt <= issued_cnt + CNT_ONE;
                // After the final read the address stays put.
                if (!last_issue) begin
                    addr_reg <= addr_next;
                end
            end
            inflight <= issue;
            done_reg <= start_zero || last_pop;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the FIFO storage is reset as well because its head drives
            // m_data directly and m_data must read 0 after reset.
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr_ptr] <= mem_data_out;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign mem_addr     = addr_reg;
    assign mem_write_en = 1'b0;
    assign mem_data_in  = '0;
    assign m_valid      = (fifo_count != 2'd0);
    assign m_data       = fifo_mem[fifo_rd_ptr];
    assign done         = done_reg;

endmodule

// File: tb/tb_bram_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_bram_stream_reader
//
// Self-checking bench for bram_stream_reader. A behavioural RAM answers reads
// one cycle after the address. When a start is accepted the reference model
// computes the whole burst (addresses walked modulo 2**AW) and queues the
// expected words; a monitor on the falling edge pops and compares on every
// handshake and also tracks busy, done, first-word latency, stall stability
// and the reset state.
// ----------------------------------------------------------------------------
module tb_bram_stream_reader;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   len;
    logic [AW-1:0] mem_addr;
    logic          mem_write_en;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
    logic          done;

    bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_addr   (start_addr),
        .len          (len),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .busy         (busy),
        .done         (done)
    );

    initial forever #5 clk = ~clk;

    // Behavioural single-port RAM, one-cycle read latency
    logic [DW-1:0] ram [2**AW];
    always @(posedge clk) mem_data_out <= ram[mem_addr];

    // ------------------------------------------------------------------
    // Counters and check task
    // ------------------------------------------------------------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Sink: 0 = always ready, 1 = random, 2 = held low
    // ------------------------------------------------------------------
    int ready_mode = 0;
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Reference model + monitor (falling edge)
    // ------------------------------------------------------------------
    logic [DW-1:0] exp_q[$];
    int            words_left   = 0;
    bit            m_busy       = 1'b0;
    bit            m_done_exp   = 1'b0;
    bit            rst_prev     = 1'b0;
    bit            prev_stall   = 1'b0;
    logic [DW-1:0] prev_data    = '0;
    int            lat_cnt      = 0;
    int            cyc          = 0;
    int            acc_cyc      = 0;
    int            acc_len      = 0;
    bit            tput_pending = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;

        // --- compare outputs produced by the last rising edge ---
        if (rst_prev) begin
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_m_data", 32'(m_data), 32'd0);
            check("rst_mem_addr", 32'(mem_addr), 32'd0);
        end
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done_exp));
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) check("first_valid", 32'(m_valid), 32'd1);
            else              check("early_valid", 32'(m_valid), 32'd0);
        end
        if (prev_stall) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid && exp_q.size() == 0)
            check("spurious_valid", 32'(m_valid), 32'd0);
        if (m_done_exp && tput_pending) begin
            check("burst_cycles", 32'(cyc - acc_cyc), 32'(acc_len + 3));
            tput_pending = 1'b0;
        end

        // --- advance the model to what the next rising edge produces ---
        if (!rst_n) begin
            exp_q.delete();
            words_left   = 0;
            m_busy       = 1'b0;
            m_done_exp   = 1'b0;
            prev_stall   = 1'b0;
            lat_cnt      = 0;
            tput_pending = 1'b0;
            rst_prev     = 1'b1;
        end else begin
            bit old_busy;
            bit new_done;
            old_busy = m_busy;
            new_done = 1'b0;
            rst_prev = 1'b0;
            if (m_valid && m_ready && exp_q.size() > 0) begin
                logic [DW-1:0] want;
                want = exp_q.pop_front();
                check("m_data", 32'(m_data), 32'(want));
                words_left--;
                if (words_left == 0) begin
                    m_busy   = 1'b0;
                    new_done = 1'b1;
                end
            end
            if (start && !old_busy) begin
                if (len == '0) begin
                    new_done = 1'b1;
                end else begin
                    for (int i = 0; i < int'(len); i++) begin
                        logic [AW-1:0] a;
`ifdef RD_REVERSE_EN
                        a = start_addr - AW'(i);
`else
                        a = start_addr + AW'(i);
`endif
                        exp_q.push_back(ram[a]);
                    end
                    words_left   = int'(len);
                    m_busy       = 1'b1;
                    lat_cnt      = 3;
                    acc_cyc      = cyc;
                    acc_len      = int'(len);
                    tput_pending = (ready_mode == 0);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            m_done_exp = new_done;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic burst(input logic [AW-1:0] a, input logic [AW:0] l);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = a;
        len        = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!m_busy && exp_q.size() == 0) break;
        end
        check("idle_timeout", 32'(m_busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [AW-1:0] saved_addr;

        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        len        = '0;
        for (int a = 0; a < 2**AW; a++) ram[a] = DW'(a);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mem_write_en", 32'(mem_write_en), 32'd0);
        check("mem_data_in", 32'(mem_data_in), 32'd0);

        // Basic burst, full rate
        ready_mode = 0;
        burst(8'h10, 9'd4);
        wait_idle(50);

        // Wrap-around in either direction
        burst(8'hFE, 9'd4);
        wait_idle(50);
        burst(8'h01, 9'd4);
        wait_idle(50);

        // Zero-length burst: no read, no valid, done next cycle
        saved_addr = mem_addr;
        burst(8'h55, 9'd0);
        repeat (3) @(negedge clk);
        check("len0_mem_addr", 32'(mem_addr), 32'(saved_addr));

        // Second start while busy is ignored
        burst(8'h30, 9'd4);
        burst(8'h50, 9'd3);
        wait_idle(50);

        // Stalling sink, including 5 cycles held low
        ready_mode = 1;
        burst(8'h60, 9'd8);
        repeat (4) @(posedge clk);
        ready_mode = 2;
        repeat (5) @(posedge clk);
        ready_mode = 1;
        wait_idle(100);
        ready_mode = 0;

        // Full address space
        burst(8'h80, 9'd256);
        wait_idle(600);

        // Reset after 2 of 6 words, then start on the first edge out of reset
        burst(8'h40, 9'd6);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (words_left <= 4) break;
        end
        check("reset_point", 32'(words_left <= 4), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        start      = 1'b1;
        start_addr = 8'h20;
        len        = 9'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(50);

        // Randomized bursts with random sink behaviour and random content
        for (int a = 0; a < 2**AW; a++) ram[a] = DW'($urandom);
        for (int k = 0; k < 25; k++) begin
            ready_mode = $urandom_range(0, 1);
            burst(AW'($urandom), 9'($urandom_range(0, 20)));
            if ($urandom_range(0, 2) == 0)
                burst(AW'($urandom), 9'($urandom_range(1, 20)));
            wait_idle(200);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
